prga: RTL and testbench
=======================

PRGA -- requirements
Module: prga

Interface
REQ-001 Parameters: none; all widths fixed at 8-bit data and 8-bit addresses.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 en  input  1  start request; sampled only while rdy=1.
REQ-005 rdy  output  1  high = idle and able to accept en.
REQ-006 s_addr  output  8  S-memory address (state array, 256x8, written by upstream ksa).
REQ-007 s_rddata  input  8  S-memory read data, one cycle after s_addr.
REQ-008 s_wrdata  output  8  S-memory write data.
REQ-009 s_wren  output  1  S-memory write enable.
REQ-010 ct_addr  output  8  ciphertext memory address.
REQ-011 ct_rddata  input  8  ciphertext read data, one cycle after ct_addr.
REQ-012 pt_addr  output  8  plaintext memory address.
REQ-013 pt_wrdata  output  8  plaintext write data.
REQ-014 pt_wren  output  1  plaintext write enable.

Function
REQ-015 All three memories are synchronous single-port RAMs: read data valid exactly one cycle after address; a write occurs on the edge where wren=1.
REQ-016 Message format: ct[0]=length L (0..255); ct[1..L]=ciphertext bytes; pt has the same layout.
REQ-017 Handshake: when rdy=1 and en=1 on an edge, the run starts and rdy=0 from the next cycle; en while rdy=0 is ignored.
REQ-018 A run first reads L from ct[0] and writes pt[0]=L.
REQ-019 Registers i, j cleared to 0 at run start; for k=1..L in order: i=(i+1) mod 256; j=(j+S[i]) mod 256; swap S[i], S[j] in S memory; pad=S[(S[i]+S[j]) mod 256] using post-swap values; pt[k]=pad XOR ct[k].
REQ-020 All index sums are 8-bit with carry discarded.
REQ-021 Swap with i==j leaves S unchanged and both write cycles still occur.
REQ-022 At most one S-memory access (read or write) per cycle; pt written once per k, never out of order.
REQ-023 L=0: only pt[0]=0 is written; S not read or written; rdy returns high.
REQ-024 L=255: k runs to 255 without counter overflow; i ends at 255.
REQ-025 Total run latency from accepting en to rdy=1 is at most 10*L+8 cycles.
REQ-026 On completion rdy=1 is asserted; if en=1 in that same cycle a new run starts immediately (back-to-back runs allowed).
REQ-027 S memory is left in its final permuted state; the block never restores it.
REQ-028 s_wren and pt_wren are 0 in every cycle not performing a write.

Reset
REQ-029 While rst=1: rdy=1, s_wren=0, pt_wren=0, all addresses/write data 0, i=j=k=0, FSM idle.
REQ-030 rst asserted mid-run aborts immediately; no further writes occur; memory contents already written remain.
REQ-031 After rst deasserts, the block waits for en; no run starts spontaneously.

Verification
REQ-032 S identity (S[x]=x), ct={0x01,0x41}, pulse en -> pt={0x01,0x43}; S[1]=1 unchanged; rdy high within 18 cycles.
REQ-033 S identity, ct={0x02,0x00,0x00} -> pt={0x02,0x02,0x05}; afterwards S[2]=3, S[3]=2, all other S entries unchanged.
REQ-034 ct[0]=0x00 -> pt[0]=0x00 only; s_wren never high; pt_wren high exactly once.
REQ-035 Assert rst 20 cycles into a run with L=50 -> rdy=1 and no wren during reset; new en then completes a correct run against the current S contents.
REQ-036 Pulse en while rdy=0 -> ignored; run count and pt contents match a single run.
REQ-037 ct[0]=0xFF with a reference-model S and ct -> all 256 pt bytes match the model; no address wraps beyond 0xFF.

Source files
------------

// File: rtl/prga_if.sv
// PRGA memory/handshake bundle: start handshake plus the S, ciphertext and
// plaintext memory ports. The master side is the PRGA engine, the slave side
// is the memories and the requester.
interface prga_if;
  logic       en;
  logic       rdy;
  logic [7:0] s_addr;
  logic [7:0] s_rddata;
  logic [7:0] s_wrdata;
  logic       s_wren;
  logic [7:0] ct_addr;
  logic [7:0] ct_rddata;
  logic [7:0] pt_addr;
  logic [7:0] pt_wrdata;
  logic       pt_wren;

  modport master (
    input  en, s_rddata, ct_rddata,
    output rdy, s_addr, s_wrdata, s_wren, ct_addr, pt_addr, pt_wrdata, pt_wren
  );

  modport slave (
    output en, s_rddata, ct_rddata,
    input  rdy, s_addr, s_wrdata, s_wren, ct_addr, pt_addr, pt_wrdata, pt_wren
  );
endinterface

// File: rtl/prga.sv
// RC4 pseudo-random generation / decrypt engine. Reads length L from ct[0],
// writes pt[0]=L, then for k=1..L steps i/j, swaps S[i]/S[j] in S memory and
// writes pt[k] = S[S[i]+S[j]] ^ ct[k]. All memory ports are registered; the
// output decode computes the values the memories must see in the next cycle.
// Each k takes 8 cycles: two reads, two writes, one pad read, with waits for
// the one-cycle read latency of the synchronous RAMs.
module prga (
  input logic   clk,
  input logic   rst,
  prga_if.master bus
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_LEN_WAIT, ST_LEN, ST_SI_WAIT, ST_SI, ST_SJ_WAIT, ST_SJ,
    ST_W1, ST_W2, ST_P_WAIT, ST_P
  } state_t;

  state_t     state_r, state_nxt_s;

  logic [7:0] len_r, i_r, j_r, k_r, si_r, sj_r;
  logic [7:0] len_s, i_s, j_s, k_s, si_s, sj_s;

  logic       rdy_r, s_wren_r, pt_wren_r;
  logic       rdy_s, s_wren_s, pt_wren_s;
  logic [7:0] s_addr_r, s_wrdata_r, ct_addr_r, pt_addr_r, pt_wrdata_r;
  logic [7:0] s_addr_s, s_wrdata_s, ct_addr_s, pt_addr_s, pt_wrdata_s;

  // State register; reset aborts any run and returns to idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode: fixed 8-cycle sequence per byte, exit after k == L.
  always_comb begin
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE:     state_nxt_s = bus.en ? ST_LEN_WAIT : ST_IDLE;
      ST_LEN_WAIT: state_nxt_s = ST_LEN;
      ST_LEN:      state_nxt_s = (bus.ct_rddata == 8'd0) ? ST_IDLE : ST_SI_WAIT;
      ST_SI_WAIT:  state_nxt_s = ST_SI;
      ST_SI:       state_nxt_s = ST_SJ_WAIT;
      ST_SJ_WAIT:  state_nxt_s = ST_SJ;
      ST_SJ:       state_nxt_s = ST_W1;
      ST_W1:       state_nxt_s = ST_W2;
      ST_W2:       state_nxt_s = ST_P_WAIT;
      ST_P_WAIT:   state_nxt_s = ST_P;
      ST_P:        state_nxt_s = (k_r == len_r) ? ST_IDLE : ST_SI_WAIT;
      default:     state_nxt_s = ST_IDLE;
    endcase
  end

  // Output and datapath decode: values the memories/registers take next cycle.
  always_comb begin
    len_s       = len_r;
    i_s         = i_r;
    j_s         = j_r;
    k_s         = k_r;
    si_s        = si_r;
    sj_s        = sj_r;
    s_addr_s    = s_addr_r;
    s_wrdata_s  = s_wrdata_r;
    ct_addr_s   = ct_addr_r;
    pt_addr_s   = pt_addr_r;
    pt_wrdata_s = pt_wrdata_r;
    s_wren_s    = 1'b0;
    pt_wren_s   = 1'b0;
    rdy_s       = (state_nxt_s == ST_IDLE);
    case (state_r)
      ST_IDLE: begin
        if (bus.en) begin
          ct_addr_s = 8'd0;
          i_s       = 8'd0;
          j_s       = 8'd0;
          k_s       = 8'd0;
        end else begin
          ct_addr_s = ct_addr_r;
        end
      end
      ST_LEN: begin
        len_s       = bus.ct_rddata;
        pt_addr_s   = 8'd0;
        pt_wrdata_s = bus.ct_rddata;
        pt_wren_s   = 1'b1;
        if (bus.ct_rddata != 8'd0) begin
          i_s       = i_r + 8'd1;
          k_s       = 8'd1;
          s_addr_s  = i_r + 8'd1;
          ct_addr_s = 8'd1;
        end else begin
          k_s = k_r;
        end
      end
      ST_SI: begin
        si_s     = bus.s_rddata;
        j_s      = j_r + bus.s_rddata;
        s_addr_s = j_r + bus.s_rddata;
      end
      ST_SJ: begin
        // First swap write: S[i] <= old S[j].
        sj_s       = bus.s_rddata;
        s_addr_s   = i_r;
        s_wrdata_s = bus.s_rddata;
        s_wren_s   = 1'b1;
      end
      ST_W1: begin
        // Second swap write: S[j] <= old S[i]; still issued when i == j.
        s_addr_s   = j_r;
        s_wrdata_s = si_r;
        s_wren_s   = 1'b1;
      end
      ST_W2: begin
        // Post-swap S[i]+S[j] equals pre-swap sj+si, so no re-read needed.
        s_addr_s = si_r + sj_r;
      end
      ST_P: begin
        pt_addr_s   = k_r;
        pt_wrdata_s = bus.s_rddata ^ bus.ct_rddata;
        pt_wren_s   = 1'b1;
        if (k_r != len_r) begin
          k_s       = k_r + 8'd1;
          i_s       = i_r + 8'd1;
          s_addr_s  = i_r + 8'd1;
          ct_addr_s = k_r + 8'd1;
        end else begin
          k_s = k_r;
        end
      end
      default: begin
        rdy_s = (state_nxt_s == ST_IDLE);
      end
    endcase
  end

  // Datapath and output registers; all outputs come straight from flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_r       <= 8'd0;
      i_r         <= 8'd0;
      j_r         <= 8'd0;
      k_r         <= 8'd0;
      si_r        <= 8'd0;
      sj_r        <= 8'd0;
      rdy_r       <= 1'b1;
      s_wren_r    <= 1'b0;
      pt_wren_r   <= 1'b0;
      s_addr_r    <= 8'd0;
      s_wrdata_r  <= 8'd0;
      ct_addr_r   <= 8'd0;
      pt_addr_r   <= 8'd0;
      pt_wrdata_r <= 8'd0;
    end else begin
      len_r       <= len_s;
      i_r         <= i_s;
      j_r         <= j_s;
      k_r         <= k_s;
      si_r        <= si_s;
      sj_r        <= sj_s;
      rdy_r       <= rdy_s;
      s_wren_r    <= s_wren_s;
      pt_wren_r   <= pt_wren_s;
      s_addr_r    <= s_addr_s;
      s_wrdata_r  <= s_wrdata_s;
      ct_addr_r   <= ct_addr_s;
      pt_addr_r   <= pt_addr_s;
      pt_wrdata_r <= pt_wrdata_s;
    end
  end

  assign bus.rdy       = rdy_r;
  assign bus.s_addr    = s_addr_r;
  assign bus.s_wrdata  = s_wrdata_r;
  assign bus.s_wren    = s_wren_r;
  assign bus.ct_addr   = ct_addr_r;
  assign bus.pt_addr   = pt_addr_r;
  assign bus.pt_wrdata = pt_wrdata_r;
  assign bus.pt_wren   = pt_wren_r;

endmodule

// File: tb/tb_prga.sv
// Bench for prga: models the three synchronous RAMs, pushes expected
// plaintext writes {addr,data} into a queue, and a monitor pops and compares
// every pt write the engine makes.
module tb_prga;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prga_if bus();
  prga dut (.clk(clk), .rst(rst), .bus(bus));

  logic [7:0]  s_mem  [256];
  logic [7:0]  ct_mem [256];
  logic [7:0]  ms     [256];
  logic        init_go;
  int          init_kind;
  logic [15:0] exp_q  [$];

  int checks = 0, errors = 0, mon_checks = 0, mon_errors = 0;
  int s_wr_cnt = 0, pt_wr_cnt = 0, run_cnt = 0;

  // Synchronous RAM models: read data one cycle after address, write on wren.
  always @(posedge clk) begin
    bus.s_rddata  <= s_mem[bus.s_addr];
    bus.ct_rddata <= ct_mem[bus.ct_addr];
    if (init_go) begin
      for (int x = 0; x < 256; x++)
        s_mem[x] <= (init_kind == 0) ? 8'(x) : 8'(x * 7 + 3);
    end else if (bus.s_wren) begin
      s_mem[bus.s_addr] <= bus.s_wrdata;
    end
  end

  // Monitor: counts writes/runs and checks each pt write against the queue.
  initial begin : monitor
    logic        rdy_prev;
    logic [15:0] exp, act;
    rdy_prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.s_wren) s_wr_cnt++;
        if (rdy_prev && !bus.rdy) run_cnt++;
        if (bus.pt_wren) begin
          pt_wr_cnt++;
          mon_checks++;
          act = {bus.pt_addr, bus.pt_wrdata};
          if (exp_q.size() == 0) begin
            mon_errors++;
            $display("FAIL pt_write unexpected actual=%h required=none", act);
          end else begin
            exp = exp_q.pop_front();
            if (act !== exp) begin
              mon_errors++;
              $display("FAIL pt_write actual=%h required=%h", act, exp);
            end
          end
        end
      end
      rdy_prev = bus.rdy;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic load_s(input int kind);
    @(negedge clk);
    init_kind = kind;
    init_go   = 1'b1;
    @(negedge clk);
    init_go   = 1'b0;
  endtask

  task automatic pulse_en();
    @(negedge clk);
    bus.en = 1'b1;
    @(negedge clk);
    bus.en = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int lat;
    lat = 0;
    while (1) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.rdy || lat > budget) break;
    end
    check(name, 32'(lat <= budget), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  // Reference RC4 PRGA over ms[] and ct_mem[], pushing expected pt writes.
  task automatic model_run();
    logic [7:0] mi, mj, t, idx;
    int len;
    len = int'(ct_mem[0]);
    exp_q.push_back({8'h00, ct_mem[0]});
    mi = 8'd0;
    mj = 8'd0;
    for (int k = 1; k <= len; k++) begin
      mi = mi + 8'd1;
      mj = mj + ms[mi];
      t = ms[mi]; ms[mi] = ms[mj]; ms[mj] = t;
      idx = ms[mi] + ms[mj];
      exp_q.push_back({8'(k), ms[idx] ^ ct_mem[k]});
    end
  endtask

  function automatic int s_diff_model();
    int bad;
    bad = 0;
    for (int x = 0; x < 256; x++) if (s_mem[x] !== ms[x]) bad++;
    return bad;
  endfunction

  initial begin : main
    int sw0, pw0, rc0, bad;
    rst = 1'b1; bus.en = 1'b0; init_go = 1'b0; init_kind = 0;
    for (int x = 0; x < 256; x++) ct_mem[x] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdy", 32'(bus.rdy), 32'd1);
    check("rst_wren", {30'd0, bus.s_wren, bus.pt_wren}, 32'd0);
    check("rst_addr", {bus.s_addr, bus.ct_addr, bus.pt_addr, 8'h00}, 32'd0);
    check("rst_wdata", {16'd0, bus.s_wrdata, bus.pt_wrdata}, 32'd0);
    load_s(0);
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    check("no_spont_run", 32'(run_cnt), 32'd0);

    // L=1, identity S: pad = S[2] = 2, 0x41^0x02 = 0x43.
    ct_mem[0] = 8'h01; ct_mem[1] = 8'h41;
    exp_q.push_back(16'h0001); exp_q.push_back(16'h0143);
    sw0 = s_wr_cnt; pw0 = pt_wr_cnt;
    pulse_en();
    wait_idle("t1_latency", 18);
    check("t1_s1", 32'(s_mem[1]), 32'd1);
    check("t1_s_writes", 32'(s_wr_cnt - sw0), 32'd2);
    check("t1_pt_writes", 32'(pt_wr_cnt - pw0), 32'd2);
    check("t1_q_empty", 32'(exp_q.size()), 32'd0);

    // L=2 zero ciphertext, identity S: pads 2 then 5; S[2]/S[3] swapped.
    load_s(0);
    ct_mem[0] = 8'h02; ct_mem[1] = 8'h00; ct_mem[2] = 8'h00;
    exp_q.push_back(16'h0002); exp_q.push_back(16'h0102); exp_q.push_back(16'h0205);
    sw0 = s_wr_cnt;
    pulse_en();
    wait_idle("t2_latency", 28);
    check("t2_s2", 32'(s_mem[2]), 32'd3);
    check("t2_s3", 32'(s_mem[3]), 32'd2);
    bad = 0;
    for (int x = 0; x < 256; x++) if (x != 2 && x != 3 && s_mem[x] !== 8'(x)) bad++;
    check("t2_s_others", 32'(bad), 32'd0);
    check("t2_s_writes", 32'(s_wr_cnt - sw0), 32'd4);
    check("t2_q_empty", 32'(exp_q.size()), 32'd0);

    // L=0: only pt[0]=0, no S writes.
    ct_mem[0] = 8'h00;
    exp_q.push_back(16'h0000);
    sw0 = s_wr_cnt; pw0 = pt_wr_cnt;
    pulse_en();
    wait_idle("t3_latency", 8);
    check("t3_s_writes", 32'(s_wr_cnt - sw0), 32'd0);
    check("t3_pt_writes", 32'(pt_wr_cnt - pw0), 32'd1);
    check("t3_q_empty", 32'(exp_q.size()), 32'd0);

    // en while busy is ignored: one run, same result as test 1.
    load_s(0);
    ct_mem[0] = 8'h01; ct_mem[1] = 8'h41;
    exp_q.push_back(16'h0001); exp_q.push_back(16'h0143);
    rc0 = run_cnt; pw0 = pt_wr_cnt;
    pulse_en();
    repeat (2) @(negedge clk);
    bus.en = 1'b1;
    @(negedge clk);
    bus.en = 1'b0;
    wait_idle("t4_latency", 18);
    repeat (5) @(negedge clk);
    check("t4_runs", 32'(run_cnt - rc0), 32'd1);
    check("t4_pt_writes", 32'(pt_wr_cnt - pw0), 32'd2);
    check("t4_q_empty", 32'(exp_q.size()), 32'd0);

    // Reset 20 cycles into an L=50 run, then rerun against current S.
    load_s(1);
    ct_mem[0] = 8'd50;
    for (int k = 1; k <= 50; k++) ct_mem[k] = 8'(k * 3);
    for (int x = 0; x < 256; x++) ms[x] = s_mem[x];
    model_run();
    pulse_en();
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b1;
    pw0 = pt_wr_cnt;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst_mid_rdy", 32'(bus.rdy), 32'd1);
      check("rst_mid_wren", {30'd0, bus.s_wren, bus.pt_wren}, 32'd0);
    end
    exp_q.delete();
    @(negedge clk); rst = 1'b0;
    rc0 = run_cnt;
    repeat (4) @(negedge clk);
    check("t5_idle_after_rst", {30'd0, bus.rdy, 1'b0}, 32'd2);
    check("t5_no_spont_run", 32'(run_cnt - rc0), 32'd0);
    check("t5_no_pt_after_abort", 32'(pt_wr_cnt - pw0), 32'd0);
    for (int x = 0; x < 256; x++) ms[x] = s_mem[x];
    model_run();
    pulse_en();
    wait_idle("t5_latency", 10 * 50 + 8);
    check("t5_q_empty", 32'(exp_q.size()), 32'd0);
    check("t5_s_final", 32'(s_diff_model()), 32'd0);

    // L=255 against the reference model, random ciphertext.
    ct_mem[0] = 8'hFF;
    for (int k = 1; k <= 255; k++) ct_mem[k] = 8'($urandom_range(0, 255));
    for (int x = 0; x < 256; x++) ms[x] = s_mem[x];
    model_run();
    rc0 = run_cnt; pw0 = pt_wr_cnt;
    pulse_en();
    wait_idle("t6_latency", 10 * 255 + 8);
    check("t6_pt_writes", 32'(pt_wr_cnt - pw0), 32'd256);
    check("t6_runs", 32'(run_cnt - rc0), 32'd1);
    check("t6_q_empty", 32'(exp_q.size()), 32'd0);
    check("t6_s_final", 32'(s_diff_model()), 32'd0);

    checks = checks + mon_checks;
    errors = errors + mon_errors;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
